// File: rtl/spi_output_controller.sv
// SPI slave transmitter (mode 0, LSB-first) that returns one classification result to the
// external SPI master. A result (digit + 16-bit cost) is latched on result_valid. It is then
// shifted out on MISO while the master clocks SCK with SS low. SCK and SS are asynchronous and
// are synchronised into the clk domain before edge detection.
//
// Optional feature: define SPI_OUT_CHECKSUM_EN to append byte3 = byte0 ^ byte1 ^ byte2.
// The frame is then 4 bytes long instead of 3.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   SCK, SS      SPI clock and active-low slave select from the master (async)
//   result_valid one-cycle pulse qualifying result_digit / result_cost
//   result_digit predicted digit (sent unchanged, no range check)
//   result_cost  16-bit unsigned cost
//   MISO         serial data to master
//   MISO_oe      tri-state enable, high while synchronised SS is low
//   tx_busy      a result is loaded and not yet fully transmitted
//   tx_done      one-cycle pulse after the final bit has been sampled
//   overflow     sticky: result_valid arrived while tx_busy
module spi_output_controller #(
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2    // 2 or 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCK,
  input  logic        SS,
  input  logic        result_valid,
  input  logic [3:0]  result_digit,
  input  logic [15:0] result_cost,
  output logic        MISO,
  output logic        MISO_oe,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        overflow
);

`ifdef SPI_OUT_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 4;
`else
  localparam int unsigned FRAME_BYTES = 3;
`endif
  localparam int unsigned FRAME_W   = FRAME_BYTES * 8;
  localparam logic [1:0]  LAST_BYTE = 2'(FRAME_BYTES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOADED = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Synchronisers plus one extra flop each for edge detection. SS resets high so that
  // no false ss_fall appears when reset is released.
  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q;
  logic                   sck_d1_q, ss_d1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= '0;
      ss_sync_q  <= '1;
      sck_d1_q   <= 1'b0;
      ss_d1_q    <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      sck_d1_q   <= sck_sync_q[SYNC_STAGES-1];
      ss_d1_q    <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, ss_s, sck_rise, sck_fall, ss_fall, ss_rise;
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  // SCK activity only counts while the slave is selected.
  assign sck_rise = sck_s & ~sck_d1_q & ~ss_s;
  assign sck_fall = ~sck_s & sck_d1_q & ~ss_s;
  assign ss_fall  = ~ss_s & ss_d1_q;
  assign ss_rise  = ss_s & ~ss_d1_q;

  // Frame assembled from the live inputs; only captured on an accepted load.
  logic [7:0]         byte0;
  logic [FRAME_W-1:0] new_frame;
  assign byte0 = {4'h0, result_digit};
`ifdef SPI_OUT_CHECKSUM_EN
  assign new_frame = {byte0 ^ result_cost[7:0] ^ result_cost[15:8], result_cost, byte0};
`else
  assign new_frame = {result_cost, byte0};
`endif

  logic [1:0]         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic               miso_q, miso_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    miso_d  = miso_q;
    ovf_d   = ovf_q | (result_valid & (state_q != ST_IDLE));
    unique case (state_q)
      ST_IDLE: begin
        if (result_valid) begin
          // Load wins over a coincident ss_fall; SHIFT waits for the next SS assertion.
          frame_d = new_frame;
          state_d = ST_LOADED;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end else if (ss_fall) begin
          bit_d  = 3'd0;
          miso_d = IDLE_BYTE[0];
        end else if (sck_rise) begin
          bit_d = bit_q + 3'd1;
        end else if (sck_fall) begin
          miso_d = IDLE_BYTE[bit_q];
        end
      end
      ST_LOADED: begin
        if (ss_fall) begin
          state_d = ST_SHIFT;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          miso_d  = frame_q[0];
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          // Abort: keep the frame, restart from byte0 bit0 on the next assertion.
          state_d = ST_LOADED;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
        end else if (sck_rise) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            byte_d = byte_q + 2'd1;
            if (byte_q == LAST_BYTE) state_d = ST_DONE;
          end
        end else if (sck_fall) begin
          miso_d = frame_q[{byte_q, bit_q}];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        bit_d   = 3'd0;
        byte_d  = 2'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      miso_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      miso_q  <= miso_d;
      ovf_q   <= ovf_d;
    end
  end

  assign MISO     = miso_q;
  assign MISO_oe  = ~ss_s;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = (state_q == ST_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_spi_output_controller.sv
// Self-checking bench for spi_output_controller: acts as the SPI master (mode 0, LSB-first)
// and compares every frame read back against a byte-level model of the result frame.
module tb_spi_output_controller;

`ifdef SPI_OUT_CHECKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif
  localparam int NBITS = FB * 8;
  localparam int HALF  = 6;  // SCK half-period in clk cycles

  logic        clk, rst, SCK, SS, result_valid;
  logic [3:0]  result_digit;
  logic [15:0] result_cost;
  logic        MISO, MISO_oe, tx_busy, tx_done, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  spi_output_controller dut (
    .clk          (clk),
    .rst          (rst),
    .SCK          (SCK),
    .SS           (SS),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .result_cost  (result_cost),
    .MISO         (MISO),
    .MISO_oe      (MISO_oe),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done) done_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the frame as a list of bytes, packed LSB-byte first into 32 bits.
  function automatic logic [31:0] model_frame(input int digit, input int cost);
    int b[4];
    b[0] = digit;
    b[1] = cost % 256;
    b[2] = (cost / 256) % 256;
    b[3] = (FB == 4) ? (b[0] ^ b[1] ^ b[2]) : 0;
    return 32'(b[0] + b[1] * 256 + b[2] * 65536 + b[3] * 16777216);
  endfunction

  function automatic logic [31:0] low_bits(input logic [31:0] v, input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return v & m[31:0];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] d, input logic [15:0] c);
    @(negedge clk);
    result_valid = 1'b1;
    result_digit = d;
    result_cost  = c;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  // Master transfer: assert SS, clock nbits, sampling MISO just before each rising edge.
  task automatic xfer(input int nbits, input bit raise_ss, output logic [31:0] data,
                      output int done_pre);
    data     = '0;
    done_pre = done_cnt;
    SS = 1'b0;
    wait_cycles(HALF);
    for (int i = 0; i < nbits; i++) begin
      data[i] = MISO;
      if (i == nbits - 1) done_pre = done_cnt;
      SCK = 1'b1;
      wait_cycles(HALF);
      SCK = 1'b0;
      wait_cycles(HALF);
    end
    if (raise_ss) begin
      SS = 1'b1;
      wait_cycles(HALF);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; SCK = 1'b0; SS = 1'b1;
    result_valid = 1'b0; result_digit = '0; result_cost = '0;
    wait_cycles(3);
    n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL reset_miso got %b want 1", MISO); end
    n_checks++; if (MISO_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", MISO_oe); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", tx_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    rst = 1'b0;
    wait_cycles(3);
  endtask

  task automatic test_idle_read;
    logic [31:0] data;
    int d0, dp;
    d0 = done_cnt;
    xfer(8, 1'b0, data, dp);
    n_checks++; if (MISO_oe !== 1'b1) begin n_fail++; $display("FAIL idle_oe_low got %b want 1", MISO_oe); end
    SS = 1'b1;
    wait_cycles(HALF);
    n_checks++; if (MISO_oe !== 1'b0) begin n_fail++; $display("FAIL idle_oe_high got %b want 0", MISO_oe); end
    n_checks++; if (data[7:0] !== 8'hFF) begin n_fail++; $display("FAIL idle_byte got %h want ff", data[7:0]); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", tx_busy); end
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL idle_done got %0d want %0d", done_cnt, d0); end
  endtask

  task automatic test_frame;
    logic [31:0] data, exp;
    int d0, dp;
    exp = model_frame(7, 16'h1234);
    d0 = done_cnt;
    load(4'd7, 16'h1234);
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy got %b want 1", tx_busy); end
    xfer(NBITS, 1'b1, data, dp);
    n_checks++; if (data !== exp) begin n_fail++; $display("FAIL frame_data got %h want %h", data, exp); end
    n_checks++; if (dp !== d0) begin n_fail++; $display("FAIL frame_early_done got %0d want %0d", dp, d0); end
    n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL frame_done got %0d want %0d", done_cnt, d0 + 1); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_end got %b want 0", tx_busy); end
  endtask

  task automatic test_abort;
    logic [31:0] data, exp;
    int d0, dp;
    exp = model_frame(7, 16'h1234);
    d0 = done_cnt;
    load(4'd7, 16'h1234);
    xfer(10, 1'b1, data, dp);
    n_checks++; if (data !== low_bits(exp, 10)) begin n_fail++; $display("FAIL abort_part got %h want %h", data, low_bits(exp, 10)); end
    n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL abort_done got %0d want %0d", done_cnt, d0); end
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", tx_busy); end
    xfer(NBITS, 1'b1, data, dp);
    n_checks++; if (data !== exp) begin n_fail++; $display("FAIL abort_full got %h want %h", data, exp); end
    n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL abort_done2 got %0d want %0d", done_cnt, d0 + 1); end
  endtask

  // SCK toggles with SS high, and a load while SS is already low, must not advance the frame.
  task automatic test_sck_ignored;
    logic [31:0] data, exp;
    int d0, dp;
    exp = model_frame(4'hC, 16'hA55A);
    d0 = done_cnt;
    SS = 1'b0;
    wait_cycles(HALF);
    load(4'hC, 16'hA55A);
    xfer(8, 1'b1, data, dp);
    for (int i = 0; i < 5; i++) begin
      SCK = 1'b1; wait_cycles(HALF);
      SCK = 1'b0; wait_cycles(HALF);
    end
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy got %b want 1", tx_busy); end
    xfer(NBITS, 1'b1, data, dp);
    n_checks++; if (data !== exp) begin n_fail++; $display("FAIL ign_data got %h want %h", data, exp); end
    n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ign_done got %0d want %0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_overflow;
    logic [31:0] data, exp;
    int d0, dp;
    exp = model_frame(7, 16'h1234);
    d0 = done_cnt;
    load(4'd7, 16'h1234);
    fork
      xfer(NBITS, 1'b1, data, dp);
      begin
        wait_cycles(40);
        load(4'd3, 16'hBEEF);
      end
    join
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_checks++; if (data !== exp) begin n_fail++; $display("FAIL ovf_data got %h want %h", data, exp); end
    n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL ovf_done got %0d want %0d", done_cnt, d0 + 1); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy got %b want 0", tx_busy); end
    xfer(8, 1'b1, data, dp);
    n_checks++; if (data[7:0] !== 8'hFF) begin n_fail++; $display("FAIL ovf_nodigit got %h want ff", data[7:0]); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] data;
    int dp;
    load(4'd7, 16'h1234);
    xfer(12, 1'b0, data, dp);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL rstmid_miso got %b want 1", MISO); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", tx_busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got %b want 0", overflow); end
    SS = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
    xfer(8, 1'b1, data, dp);
    n_checks++; if (data[7:0] !== 8'hFF) begin n_fail++; $display("FAIL rstmid_idle got %h want ff", data[7:0]); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy2 got %b want 0", tx_busy); end
  endtask

  task automatic test_random;
    logic [31:0] data, exp;
    logic [3:0]  d;
    logic [15:0] c;
    int d0, dp, n;
    for (int it = 0; it < 8; it++) begin
      d = 4'($urandom_range(0, 15));
      c = 16'($urandom);
      exp = model_frame(int'(d), int'(c));
      d0 = done_cnt;
      load(d, c);
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, NBITS - 1);
        xfer(n, 1'b1, data, dp);
        n_checks++; if (data !== low_bits(exp, n)) begin n_fail++; $display("FAIL rnd_part[%0d] got %h want %h", it, data, low_bits(exp, n)); end
      end
      xfer(NBITS, 1'b1, data, dp);
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", it, data, exp); end
      n_checks++; if (dp !== d0) begin n_fail++; $display("FAIL rnd_early[%0d] got %0d want %0d", it, dp, d0); end
      n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL rnd_done[%0d] got %0d want %0d", it, done_cnt, d0 + 1); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] data;
    int d0, dp;
    d0 = done_cnt;
    load(4'd1, 16'h00FF);
    xfer(NBITS, 1'b1, data, dp);
    n_checks++; if (data !== model_frame(1, 16'h00FF)) begin n_fail++; $display("FAIL b2b_first got %h want %h", data, model_frame(1, 16'h00FF)); end
    load(4'd9, 16'hFF00);
    xfer(NBITS, 1'b1, data, dp);
    n_checks++; if (data !== model_frame(9, 16'hFF00)) begin n_fail++; $display("FAIL b2b_second got %h want %h", data, model_frame(9, 16'hFF00)); end
    n_checks++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL b2b_done got %0d want %0d", done_cnt, d0 + 2); end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_frame();
    test_abort();
    test_sck_ignored();
    test_overflow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_output_controller.md
Name: spi_output_controller

Overview:
- SPI slave transmitter (mode 0, LSB-first) that returns classification results to the external SPI master, the host that also drives pixel/label input.
- Latches one result (predicted digit plus 16-bit cost) on a pulse from the network core, then serialises it onto MISO as the master clocks SCK with SS low.
- SCK and SS are synchronised into the clk domain. The block sits beside the SPI input controller at the chip edge.

Parameters:
- IDLE_BYTE, 8'hFF, value shifted out when SS is low and no result is loaded.
- SYNC_STAGES, 2, synchroniser depth for SCK and SS (legal values 2 or 3).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- SCK  in  1  SPI clock from master (async)
- SS  in  1  SPI slave select, active low (async)
- result_valid  in  1  one-cycle pulse: result inputs valid
- result_digit  in  4  predicted digit, 0..9
- result_cost  in  16  cost value, unsigned
- MISO  out  1  serial data to master
- MISO_oe  out  1  tri-state enable, 1 while synchronised SS is low
- tx_busy  out  1  a result is loaded and not yet fully transmitted
- tx_done  out  1  one-cycle pulse after the final bit is sampled
- overflow  out  1  sticky: result_valid arrived while tx_busy

Behaviour:
- Reset (async, rst=1) values:
  - state IDLE; MISO=1, MISO_oe=0; tx_busy=0, tx_done=0, overflow=0.
  - Frame registers and all counters cleared.
- Synchronisation:
  - SCK and SS each pass through SYNC_STAGES flops; one further flop provides the edge detect.
  - sck_rise, sck_fall and ss_fall are single-cycle strobes derived from the synchronised signals.
- Frame layout, built on result_valid while not tx_busy:
  - byte0 = {4'h0, result_digit}
  - byte1 = result_cost[7:0]
  - byte2 = result_cost[15:8]
  - FRAME_BYTES = 3. Bits within each byte are sent LSB first, bytes in order 0,1,2.
- States:
  - IDLE: no result loaded.
    - result_valid → LOADED, tx_busy=1 on the next cycle.
    - Synchronised SS low in IDLE: the host reads IDLE_BYTE repeatedly, LSB first. Nothing is consumed and there is no state change.
  - LOADED: waiting for the master. ss_fall → SHIFT, bit/byte counters reset to 0, MISO = byte0[0] in the same cycle the state changes.
  - SHIFT:
    - sck_rise increments the bit counter (3-bit) and, on its wrap from 7, the byte counter.
    - sck_fall drives the next bit onto MISO.
    - On the sck_rise that completes bit 7 of the last byte → DONE.
  - DONE: one cycle; tx_done=1, tx_busy falls to 0 on the next cycle → IDLE.
- MISO timing: MISO changes only on sck_fall or the SHIFT-entry ss_fall. The master's SCK half-period must be at least SYNC_STAGES+2 clk cycles.
- Boundary conditions:
  - SS rises (synchronised) mid-SHIFT → abort back to LOADED. The frame is retained and counters reset; the next SS assertion restarts from byte0 bit0. tx_done is not pulsed.
  - result_valid during LOADED/SHIFT/DONE → ignored and overflow set. overflow clears only on rst.
  - result_valid and ss_fall in the same cycle in IDLE → load takes effect; SHIFT entry waits for the next ss_fall.
  - SCK edges while SS is high are ignored.
  - result_digit > 9 is transmitted unchanged; no range check.
  - Asynchronous rst mid-frame → immediately back to IDLE. The loaded result is lost and MISO=1.

Optional Feature:
- Macro SPI_OUT_CHECKSUM_EN.
- Defined:
  - FRAME_BYTES = 4; byte3 = byte0 ^ byte1 ^ byte2, computed at load.
  - DONE is reached after bit 7 of byte3, so tx_done follows 32 sck_rise strobes.
- Undefined: 3-byte frame as above; no checksum logic.

Test Plan:
- Reset then SS low with no result, 8 SCK pulses → master samples 8'hFF; tx_busy=0; no tx_done.
- result_valid with digit=4'd7, cost=16'h1234, then SS low + 24 SCK → bytes read LSB-first: 8'h07, 8'h34, 8'h12. Single tx_done pulse; tx_busy=0 afterward.
- Same load; SS raised after 10 SCK, then re-asserted with 24 SCK → full 07/34/12 frame from the start. Exactly one tx_done, after the second transfer.
- Second result_valid (digit=3) during SHIFT of the first → overflow=1; first frame transmitted unchanged; digit 3 never sent.
- rst pulsed during byte1 → MISO=1 and tx_busy=0 immediately. A subsequent SS read returns 8'hFF.
- With SPI_OUT_CHECKSUM_EN, digit=7, cost=16'h1234 → 32 bits read: 07, 34, 12, 8'h21. tx_done after the 32nd rising edge.
